// File: rtl/banked_ram_dp_if.sv
// banked_ram_dp_if: lane bus for banked_ram_dp; master drives port A/B write/read requests and buffer-ID, slave returns registered read data and delayed buffer-ID
interface banked_ram_dp_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_ID_W   = 1
);
  logic [ADDR_WIDTH-1:0] s_write_addr_a, s_read_addr_a, s_write_addr_b, s_read_addr_b;
  logic                  s_write_req_a, s_read_req_a, s_write_req_b, s_read_req_b;
  logic [DATA_WIDTH-1:0] s_write_data_a, s_write_data_b, s_read_data_a, s_read_data_b;
  logic [BUF_ID_W-1:0]   local_mem_read_buf_id, local_mem_read_buf_id_dly;
  logic                  mem_read_req;
  modport master (
    output s_write_addr_a, s_write_req_a, s_write_data_a, s_read_addr_a, s_read_req_a,
    output s_write_addr_b, s_write_req_b, s_write_data_b, s_read_addr_b, s_read_req_b,
    output local_mem_read_buf_id, mem_read_req,
    input  s_read_data_a, s_read_data_b, local_mem_read_buf_id_dly
  );
  modport slave (
    input  s_write_addr_a, s_write_req_a, s_write_data_a, s_read_addr_a, s_read_req_a,
    input  s_write_addr_b, s_write_req_b, s_write_data_b, s_read_addr_b, s_read_req_b,
    input  local_mem_read_buf_id, mem_read_req,
    output s_read_data_a, s_read_data_b, local_mem_read_buf_id_dly
  );
endinterface

// File: rtl/banked_ram_dp.sv
// banked_ram_dp: 2^TAG_W-bank true dual-port RAM lane (ports clk, reset, bus: banked_ram_dp_if.slave), 1-cycle registered reads, port A wins write collisions; BANKED_RAM_WR_FWD_EN selects write-to-read forwarding instead of read-first
module banked_ram_dp #(
  parameter int TAG_W      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_ID_W   = 1
) (
  input logic          clk,
  input logic          reset,
  banked_ram_dp_if.slave bus
);
  localparam int NB    = 1 << TAG_W;
  localparam int RW    = ADDR_WIDTH - TAG_W;
  localparam int DEPTH = 1 << RW;
  logic [NB-1:0][DATA_WIDTH-1:0] bank_rd_a, bank_rd_b;
  logic [DATA_WIDTH-1:0] rd_a_d, rd_a_q, rd_b_d, rd_b_q;
  logic [BUF_ID_W-1:0]   buf_id_q;
  logic [TAG_W-1:0]      wbank_a, wbank_b, rbank_a, rbank_b;
  assign wbank_a = bus.s_write_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign wbank_b = bus.s_write_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign rbank_a = bus.s_read_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign rbank_b = bus.s_read_addr_b[ADDR_WIDTH-1 -: TAG_W];
  for (genvar g = 0; g < NB; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (!reset && bus.s_write_req_b && wbank_b == TAG_W'(g))
        mem[bus.s_write_addr_b[RW-1:0]] <= bus.s_write_data_b;
      if (!reset && bus.s_write_req_a && wbank_a == TAG_W'(g))
        mem[bus.s_write_addr_a[RW-1:0]] <= bus.s_write_data_a;
    end
    assign bank_rd_a[g] = mem[bus.s_read_addr_a[RW-1:0]];
    assign bank_rd_b[g] = mem[bus.s_read_addr_b[RW-1:0]];
  end
`ifdef BANKED_RAM_WR_FWD_EN
  always_comb begin
    rd_a_d = (bus.s_write_req_a && bus.s_write_addr_a == bus.s_read_addr_a) ? bus.s_write_data_a :
             (bus.s_write_req_b && bus.s_write_addr_b == bus.s_read_addr_a) ? bus.s_write_data_b :
             bank_rd_a[rbank_a];
    rd_b_d = (bus.s_write_req_a && bus.s_write_addr_a == bus.s_read_addr_b) ? bus.s_write_data_a :
             (bus.s_write_req_b && bus.s_write_addr_b == bus.s_read_addr_b) ? bus.s_write_data_b :
             bank_rd_b[rbank_b];
  end
`else
  always_comb begin
    rd_a_d = bank_rd_a[rbank_a];
    rd_b_d = bank_rd_b[rbank_b];
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      buf_id_q <= '0;
    end else begin
      if (bus.s_read_req_a) rd_a_q <= rd_a_d;
      if (bus.s_read_req_b) rd_b_q <= rd_b_d;
      if (bus.mem_read_req) buf_id_q <= bus.local_mem_read_buf_id;
    end
  end
  assign bus.s_read_data_a             = rd_a_q;
  assign bus.s_read_data_b             = rd_b_q;
  assign bus.local_mem_read_buf_id_dly = buf_id_q;
endmodule

// File: tb/tb_banked_ram_dp.sv
// tb_banked_ram_dp: directed-vector self-checking bench for banked_ram_dp
module tb_banked_ram_dp;
  logic clk = 0;
  logic reset = 1;
  int n_vec = 0;
  int n_bad = 0;
  banked_ram_dp_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BUF_ID_W(1)) bus ();
  banked_ram_dp #(.TAG_W(2), .ADDR_WIDTH(10), .DATA_WIDTH(32), .BUF_ID_W(1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.s_write_req_a = 0;
    bus.s_write_req_b = 0;
    bus.s_read_req_a = 0;
    bus.s_read_req_b = 0;
    bus.mem_read_req = 0;
  endtask
  task automatic wr_a(input logic [9:0] a, input logic [31:0] d);
    bus.s_write_req_a = 1;
    bus.s_write_addr_a = a;
    bus.s_write_data_a = d;
  endtask
  task automatic wr_b(input logic [9:0] a, input logic [31:0] d);
    bus.s_write_req_b = 1;
    bus.s_write_addr_b = a;
    bus.s_write_data_b = d;
  endtask
  task automatic rd_a(input logic [9:0] a);
    bus.s_read_req_a = 1;
    bus.s_read_addr_a = a;
  endtask
  task automatic rd_b(input logic [9:0] a);
    bus.s_read_req_b = 1;
    bus.s_read_addr_b = a;
  endtask
  logic [31:0] bank_exp [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
  logic [31:0] fwd_exp;
  initial begin
`ifdef BANKED_RAM_WR_FWD_EN
    fwd_exp = 32'h20;
`else
    fwd_exp = 32'hAAAA;
`endif
    idle();
    bus.s_write_addr_a = 0; bus.s_write_addr_b = 0; bus.s_read_addr_a = 0; bus.s_read_addr_b = 0;
    bus.s_write_data_a = 0; bus.s_write_data_b = 0; bus.local_mem_read_buf_id = 0;
    cyc(); cyc();
    chk("reset_rd_a", bus.s_read_data_a, 0);
    chk("reset_rd_b", bus.s_read_data_b, 0);
    chk("reset_dly", 32'(bus.local_mem_read_buf_id_dly), 0);
    reset = 0;
    cyc();
    wr_a(10'h005, 32'hDEADBEEF); cyc(); idle();
    rd_b(10'h005); cyc(); idle();
    chk("xport_a2b", bus.s_read_data_b, 32'hDEADBEEF);
    wr_b(10'h006, 32'hCAFEF00D); cyc(); idle();
    rd_a(10'h006); cyc(); idle();
    chk("xport_b2a", bus.s_read_data_a, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      wr_a(10'(i << 8), bank_exp[i]); cyc();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rd_b(10'(i << 8)); cyc();
      chk($sformatf("bank%0d", i), bus.s_read_data_b, bank_exp[i]);
    end
    idle();
    wr_a(10'h010, 32'hAAAA); wr_b(10'h010, 32'hBBBB); cyc(); idle();
    rd_a(10'h010); cyc(); idle();
    chk("collide_a_wins", bus.s_read_data_a, 32'hAAAA);
    rd_a(10'h010); wr_b(10'h010, 32'h20); cyc(); idle();
    chk("rdw_same_addr", bus.s_read_data_a, fwd_exp);
    rd_b(10'h010); cyc(); idle();
    chk("rdw_after", bus.s_read_data_b, 32'h20);
    rd_b(10'h005); cyc(); idle();
    chk("hold_pre", bus.s_read_data_b, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      wr_a(10'h005, 32'h11111111); cyc();
      chk($sformatf("hold%0d", i), bus.s_read_data_b, 32'hDEADBEEF);
    end
    idle();
    rd_b(10'h005); cyc(); idle();
    chk("hold_post", bus.s_read_data_b, 32'h11111111);
    bus.mem_read_req = 1; bus.local_mem_read_buf_id = 1; cyc();
    chk("bufid_cap", 32'(bus.local_mem_read_buf_id_dly), 1);
    bus.mem_read_req = 0; bus.local_mem_read_buf_id = 0; cyc();
    chk("bufid_hold", 32'(bus.local_mem_read_buf_id_dly), 1);
    rd_a(10'h005); cyc(); idle();
    chk("pre_rst_rd_a", bus.s_read_data_a, 32'h11111111);
    #1 reset = 1;
    #1;
    chk("async_rd_a", bus.s_read_data_a, 0);
    chk("async_rd_b", bus.s_read_data_b, 0);
    chk("async_dly", 32'(bus.local_mem_read_buf_id_dly), 0);
    wr_a(10'h005, 32'h99); rd_b(10'h005); bus.mem_read_req = 1; bus.local_mem_read_buf_id = 1;
    cyc();
    chk("rst_hold_rd_b", bus.s_read_data_b, 0);
    chk("rst_hold_dly", 32'(bus.local_mem_read_buf_id_dly), 0);
    idle();
    reset = 0;
    rd_a(10'h005); cyc(); idle();
    chk("rst_no_write", bus.s_read_data_a, 32'h11111111);
    chk("rst_dly_after", 32'(bus.local_mem_read_buf_id_dly), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/banked_ram_dp.md
Name: banked_ram_dp

Overview:
- Dual-port RAM, one lane wide (DATA_WIDTH), split into 2^TAG_W banks.
- Port A is the memory/DMA side. Port B is the compute-array buffer side.
- Sits inside each output-buffer lane.
- Also registers the lane's memory-read buffer-ID so the parent can steer 1-cycle-late read data onto the shared memory bus.

Parameters:
- TAG_W, 2, log2 of bank count; the top TAG_W address bits select the bank.
- ADDR_WIDTH, 10, word address width per port; total depth 2^ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- BUF_ID_W, 1, width of the buffer-ID side channel; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_write_addr_a  in  ADDR_WIDTH  port A write address.
- s_write_req_a  in  1  port A write enable.
- s_write_data_a  in  DATA_WIDTH  port A write data.
- s_read_addr_a  in  ADDR_WIDTH  port A read address.
- s_read_req_a  in  1  port A read enable.
- s_read_data_a  out  DATA_WIDTH  port A registered read data.
- s_write_addr_b  in  ADDR_WIDTH  port B write address.
- s_write_req_b  in  1  port B write enable.
- s_write_data_b  in  DATA_WIDTH  port B write data.
- s_read_addr_b  in  ADDR_WIDTH  port B read address.
- s_read_req_b  in  1  port B read enable.
- s_read_data_b  out  DATA_WIDTH  port B registered read data.
- local_mem_read_buf_id  in  BUF_ID_W  buffer ID accompanying the port-A read request.
- local_mem_read_buf_id_dly  out  BUF_ID_W  buffer ID registered on the mem_read_req cycle.
- mem_read_req  in  1  qualifier for capturing local_mem_read_buf_id.

Behaviour:
- Bank decode:
  - bank = addr[ADDR_WIDTH-1 -: TAG_W]; row = addr[ADDR_WIDTH-TAG_W-1:0].
  - Each bank is 2^(ADDR_WIDTH-TAG_W) x DATA_WIDTH, true dual-port (A and B).
  - Any mix of A/B accesses to the same or different banks is legal every cycle; no stalls, no arbitration.
- Writes: on a clk edge with s_write_req_x=1, mem[addr_x] <= s_write_data_x.
- Simultaneous A and B write to the same address: port A's data is stored.
- Reads:
  - s_read_req_x=1 at edge N: s_read_data_x shows mem[addr_x] after edge N (1-cycle latency).
  - s_read_req_x=0: s_read_data_x holds its previous value.
- Read-during-write to the same address (either port pairing), feature disabled: read returns the old contents (read-first).
- Buffer-ID register:
  - mem_read_req=1 at an edge: local_mem_read_buf_id_dly <= local_mem_read_buf_id.
  - mem_read_req=0: it holds.
  - This aligns with port-A read data.
- Reset (async, active-high):
  - s_read_data_a, s_read_data_b and local_mem_read_buf_id_dly clear to 0 immediately and stay 0 while reset is high.
  - Array contents are not reset.
  - Requests presented while reset is high are ignored: no writes, no register updates.
- Address wrap: none; each address maps to exactly one bank/row; the full 2^ADDR_WIDTH range is valid.

Optional Feature:
- Macro BANKED_RAM_WR_FWD_EN.
- Defined:
  - A read whose address equals a same-cycle write address (either port) returns the new write data.
  - If both ports write that address, port A data is returned.
  - Still 1-cycle latency.
- Undefined: read-first behaviour as above.

Test Plan:
- Reset then idle: assert reset mid-cycle -> s_read_data_a/b and local_mem_read_buf_id_dly read 0 without waiting for a clock edge.
- Cross-port access: write A addr 0x005 = 0xDEADBEEF; next cycle read B addr 0x005 -> s_read_data_b = 0xDEADBEEF one cycle after the request. Repeat with a B write and an A read.
- Bank independence (TAG_W=2, ADDR_WIDTH=10): write A 0x000=1, 0x100=2, 0x200=3, 0x300=4; read all four back via B -> 1,2,3,4; no aliasing between banks.
- Same-address collision:
  - A and B both write 0x010 (A=0xAAAA, B=0xBBBB) -> later read returns 0xAAAA.
  - Read 0x010 in the same cycle as writing 0x020 to 0x010 -> returns 0xAAAA without the macro, 0x20 with BANKED_RAM_WR_FWD_EN.
- Hold behaviour: read returns X; drop s_read_req for 3 cycles while writing that address -> s_read_data stays X.
- Buffer-ID delay: mem_read_req=1 with buf_id=1 -> dly=1 next cycle; mem_read_req=0 with buf_id=0 -> dly stays 1.
